// File: rtl/case_9_sdiv_9s_8s_9_seq_pkg.sv
// Shared definitions for the sequential signed divider: FSM encoding, counter sizing,
// and the quotient returned on a zero divisor.
package case_9_sdiv_9s_8s_9_seq_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StFix,
    StDone
  } state_e;

  function automatic int unsigned cnt_width(input int unsigned w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  localparam int unsigned DefDin0Width = 9;
  localparam int unsigned DefCntWidth  = cnt_width(DefDin0Width);

  // All-ones quotient reported when the divisor is zero.
  localparam logic [DefDin0Width-1:0] DivZeroQuot = '1;

endpackage

// File: rtl/case_9_sdiv_9s_8s_9_seq_step.sv
// One radix-2 restoring division step: shift in a dividend bit, trial-subtract the
// divisor magnitude, keep or restore the partial remainder.
module case_9_sdiv_9s_8s_9_seq_step #(
  parameter int unsigned RemWidth = 9
) (
  input  logic [RemWidth-1:0] i_rem,
  input  logic                i_bit,
  input  logic [RemWidth-1:0] i_dvs,
  output logic [RemWidth-1:0] o_rem,
  output logic                o_q
);

  logic [RemWidth:0]   w_shift;
  logic [RemWidth+1:0] w_diff;

  always_comb begin
    w_shift = {i_rem, i_bit};
    // One guard bit above the shifted value so the borrow is the sign of the difference.
    w_diff  = {1'b0, w_shift} - {2'b00, i_dvs};
    o_q     = ~w_diff[RemWidth+1];
    o_rem   = o_q ? w_diff[RemWidth-1:0] : w_shift[RemWidth-1:0];
  end

endmodule

// File: rtl/case_9_sdiv_9s_8s_9_seq.sv
// Multi-cycle signed divider (C semantics: truncate toward zero, remainder follows the
// dividend sign) behind an ap_start/ap_done block handshake.
module case_9_sdiv_9s_8s_9_seq
  import case_9_sdiv_9s_8s_9_seq_pkg::*;
#(
  parameter int unsigned ID         = 1,
  parameter int unsigned din0_WIDTH = 9,
  parameter int unsigned din1_WIDTH = 8,
  parameter int unsigned dout_WIDTH = 9
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic                  ap_start,
  output logic                  ap_ready,
  output logic                  ap_idle,
  output logic                  ap_done,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic [dout_WIDTH-1:0] quot,
  output logic [din1_WIDTH-1:0] remd
);

  localparam int unsigned CntW = cnt_width(din0_WIDTH);
  localparam logic [dout_WIDTH-1:0] QuotDz = dout_WIDTH'(DivZeroQuot);

  if (dout_WIDTH != din0_WIDTH) begin : g_width_check
    $error("dout_WIDTH must equal din0_WIDTH");
  end

  state_e r_state, w_state_next;

  logic [CntW-1:0]       r_cnt;
  logic [din0_WIDTH:0]   r_dvd_mag;
  logic [din1_WIDTH:0]   r_dvs_mag;
  logic                  r_dvd_neg;
  logic                  r_dvs_neg;
  logic                  r_dz;
  logic [din1_WIDTH:0]   r_rem;
  logic [din0_WIDTH-1:0] r_qmag;
  logic [dout_WIDTH-1:0] r_quot;
  logic [din1_WIDTH-1:0] r_remd;

  logic [din0_WIDTH:0]   w_din0_ext;
  logic [din1_WIDTH:0]   w_din1_ext;
  logic [din0_WIDTH:0]   w_dvd_abs;
  logic [din1_WIDTH:0]   w_dvs_abs;
  logic [din1_WIDTH:0]   w_rem_next;
  logic                  w_q_bit;
  logic [dout_WIDTH-1:0] w_quot_fix;
  logic [din1_WIDTH-1:0] w_remd_fix;

  // Magnitudes carry one extra bit so the most negative operand is representable.
  always_comb begin
    w_din0_ext = {din0[din0_WIDTH-1], din0};
    w_din1_ext = {din1[din1_WIDTH-1], din1};
    w_dvd_abs  = din0[din0_WIDTH-1] ? -w_din0_ext : w_din0_ext;
    w_dvs_abs  = din1[din1_WIDTH-1] ? -w_din1_ext : w_din1_ext;
  end

  case_9_sdiv_9s_8s_9_seq_step #(
    .RemWidth(din1_WIDTH + 1)
  ) u_step (
    .i_rem(r_rem),
    .i_bit(r_dvd_mag[r_cnt]),
    .i_dvs(r_dvs_mag),
    .o_rem(w_rem_next),
    .o_q  (w_q_bit)
  );

  always_comb begin
    w_quot_fix = '0;
    w_remd_fix = '0;
    if (r_dz) begin
      w_quot_fix = QuotDz;
      w_remd_fix = r_dvd_neg ? -r_dvd_mag[din1_WIDTH-1:0] : r_dvd_mag[din1_WIDTH-1:0];
    end else begin
      w_quot_fix = (r_dvd_neg ^ r_dvs_neg) ? -r_qmag : r_qmag;
      w_remd_fix = r_dvd_neg ? -r_rem[din1_WIDTH-1:0] : r_rem[din1_WIDTH-1:0];
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (ap_start) w_state_next = StCalc;
      StCalc:  if (r_cnt == '0) w_state_next = StFix;
      StFix:   w_state_next = StDone;
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_comb begin
    ap_idle  = (r_state == StIdle);
    ap_ready = (r_state == StIdle) && ap_start && !ap_rst;
    ap_done  = (r_state == StDone);
    quot     = r_quot;
    remd     = r_remd;
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_quot  <= '0;
      r_remd  <= '0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        StIdle: begin
          if (ap_start) begin
            r_dvd_mag <= w_dvd_abs;
            r_dvs_mag <= w_dvs_abs;
            r_dvd_neg <= din0[din0_WIDTH-1];
            r_dvs_neg <= din1[din1_WIDTH-1];
            r_dz      <= (din1 == '0);
            r_rem     <= '0;
            r_qmag    <= '0;
            r_cnt     <= CntW'(din0_WIDTH - 1);
          end
        end
        StCalc: begin
          r_rem  <= w_rem_next;
          r_qmag <= {r_qmag[din0_WIDTH-2:0], w_q_bit};
          if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
        end
        StFix: begin
          r_quot <= w_quot_fix;
          r_remd <= w_remd_fix;
        end
        default: ;
      endcase
    end
  end

endmodule
